// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator/control token codes, the keypad
// scanner state encoding and the physical key-to-token mapping.
package calc_pkg;

  localparam logic [3:0] TOK_ADD = 4'hA;
  localparam logic [3:0] TOK_SUB = 4'hB;
  localparam logic [3:0] TOK_MUL = 4'hC;
  localparam logic [3:0] TOK_DIV = 4'hD;
  localparam logic [3:0] TOK_EQ  = 4'hE;
  localparam logic [3:0] TOK_CLR = 4'hF;

  typedef enum logic [2:0] {
    ST_SCAN         = 3'd0,
    ST_DEBOUNCE     = 3'd1,
    ST_EMIT         = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_REL_DEBOUNCE = 3'd4
  } scan_state_t;

  // Keypad legend: row0 "1 2 3 A", row1 "4 5 6 B", row2 "7 8 9 C", row3 "F 0 E D".
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] tok;
    case ({row, col})
      4'h0:    tok = 4'h1;
      4'h1:    tok = 4'h2;
      4'h2:    tok = 4'h3;
      4'h3:    tok = TOK_ADD;
      4'h4:    tok = 4'h4;
      4'h5:    tok = 4'h5;
      4'h6:    tok = 4'h6;
      4'h7:    tok = TOK_SUB;
      4'h8:    tok = 4'h7;
      4'h9:    tok = 4'h8;
      4'hA:    tok = 4'h9;
      4'hB:    tok = TOK_MUL;
      4'hC:    tok = TOK_CLR;
      4'hD:    tok = 4'h0;
      4'hE:    tok = TOK_EQ;
      default: tok = TOK_DIV;
    endcase
    return tok;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0]) return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous vector; resets to all ones so an
// idle pulled-up input does not look active coming out of reset.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_token_scanner.sv
// 4x4 active-low keypad scanner: column scan, press/release debounce and
// one-cycle token strobe per accepted key press.
module keypad_token_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] Token,
  output logic       strobe,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_rs;
  logic             w_key_low;
  logic             w_sample;

  scan_state_t      r_state;
  logic [1:0]       r_col;
  logic [1:0]       r_row;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_token;
  logic             r_strobe;
  logic             r_held;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (row_in),
    .o_q   (w_rs)
  );

  // Once a key is captured only its own row is watched; other keys are ignored.
  assign w_key_low = ~w_rs[r_row];
  assign w_sample  = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SCAN;
      r_col    <= 2'd0;
      r_row    <= 2'd0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_token  <= 4'h0;
      r_strobe <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_sample) begin
            r_div <= '0;
            if (w_rs != 4'hF) begin
              r_row   <= lowest_low(w_rs);
              r_cnt   <= '0;
              r_state <= ST_DEBOUNCE;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_key_low) begin
            if (r_cnt == CNT_LAST) begin
              r_state  <= ST_EMIT;
              r_cnt    <= '0;
              r_strobe <= 1'b1;
              r_held   <= 1'b1;
              r_token  <= key_map(r_row, r_col);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_state <= ST_SCAN;
            r_col   <= r_col + 2'd1;
            r_div   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_EMIT: begin
          r_state <= ST_WAIT_RELEASE;
          r_cnt   <= '0;
        end
        ST_WAIT_RELEASE: begin
          if (!w_key_low) begin
            r_state <= ST_REL_DEBOUNCE;
            r_cnt   <= '0;
          end
        end
        ST_REL_DEBOUNCE: begin
          if (!w_key_low) begin
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_SCAN;
              r_held  <= 1'b0;
              r_col   <= r_col + 2'd1;
              r_div   <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            // Release bounce: keep holding, no new strobe.
            r_state <= ST_WAIT_RELEASE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_SCAN;
          r_div   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign col_out  = ~(4'b0001 << r_col);
  assign Token    = r_token;
  assign strobe   = r_strobe;
  assign key_held = r_held;

endmodule
